// File: rtl/pll_lock_sequencer.sv
// Purpose: turns an async PLL lock into a qualified synchronous reset and ready flag.
// Latency: release SYNC_STAGES+1+LOCK_CYCLES+HOLD_CYCLES edges after lock; loss re-asserts reset after SYNC_STAGES+1.
// Backpressure: none; `locked` is sampled every cycle. Optional PLL_LOCK_SEQ_LOSS_COUNT_EN adds the loss counter.
module pll_lock_sequencer #(
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
  output logic       rst_out,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] loss_count
);

  localparam int LW    = $clog2(LOCK_CYCLES);
  localparam int HW    = $clog2(HOLD_CYCLES);
  localparam int MW    = (LW > HW) ? LW : HW;
  localparam int CNT_W = (MW < 1) ? 1 : MW;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    STABLE = 2'd1,
    HOLD   = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic               lock_s;

  assign lock_s = sync[SYNC_STAGES-1];
  assign state  = state_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], locked};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= WAIT;
      rst_out <= 1'b1;
      ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      rst_out <= (state_d != RUN);
      ready   <= (state_d == RUN);
    end
  end

  // Counter only runs while staying in a qualification state; any transition restarts it.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if ((state_d != state_q) || (state_q == WAIT) || (state_q == RUN)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Lock drop is checked first so it wins over count completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT: begin
        if (lock_s) state_d = STABLE;
      end
      STABLE: begin
        if (!lock_s)                             state_d = WAIT;
        else if (cnt == CNT_W'(LOCK_CYCLES - 1)) state_d = HOLD;
      end
      HOLD: begin
        if (!lock_s)                             state_d = WAIT;
        else if (cnt == CNT_W'(HOLD_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        if (!lock_s) state_d = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

`ifdef PLL_LOCK_SEQ_LOSS_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      loss_count <= 8'd0;
    end else if ((state_q == RUN) && (state_d == WAIT) && (loss_count != 8'd255)) begin
      loss_count <= loss_count + 8'd1;
    end
  end
`else
  assign loss_count = 8'd0;
`endif

endmodule
